// File: rtl/mult_sched.sv
// mult_sched: round-robin arbiter and add/shift sequencer for the shared
// signed shift-add multiplier datapath. Two clients request, one is granted,
// its operands are latched and the datapath strobes are driven over the
// schedule LOAD, (ADD, SHIFT) x (WIDTH-1), SUB, SHIFT_LAST, CAPTURE.
// Optional feature macro: MULT_SCHED_SKIP_EN. When it is defined, ADD and SUB
// states are skipped for zero multiplier bits, so latency varies.
module mult_sched #(
  parameter int WIDTH = 8
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 req0,
  input  logic                 req1,
  input  logic [WIDTH-1:0]     a0,
  input  logic [WIDTH-1:0]     b0,
  input  logic [WIDTH-1:0]     a1,
  input  logic [WIDTH-1:0]     b1,
  output logic                 gnt0,
  output logic                 gnt1,
  output logic                 done0,
  output logic                 done1,
  output logic [2*WIDTH-1:0]   res0,
  output logic [2*WIDTH-1:0]   res1,
  output logic [WIDTH-1:0]     dp_opnd,
  output logic [WIDTH-1:0]     dp_mplr,
  output logic                 dp_clr_ld,
  output logic                 dp_add,
  output logic                 dp_sub,
  output logic                 dp_shift,
  input  logic                 dp_m,
  input  logic [2*WIDTH-1:0]   dp_product
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ADD,
    SHIFT,
    SUB,
    SHIFT_LAST,
    CAPTURE
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic             last_shift;
  logic             owner;
  logic             last;

  assign cnt_inc    = cnt + CNT_W'(1);
  assign last_shift = (cnt == CNT_W'(WIDTH - 2));

`ifdef MULT_SCHED_SKIP_EN
  // dp_m shows the bit being shifted out during SHIFT, one position behind the
  // bit that decides the next state, so the decision reads the latched
  // multiplier copy instead.
  logic next_bit;
  assign next_bit = dp_mplr[cnt_inc];
`endif

  // Round-robin grant; only offered while idle. Ties go to the port that did
  // not win last time.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state == IDLE) begin
      if (req0 && (!req1 || last)) begin
        gnt0 = 1'b1;
      end else if (req1) begin
        gnt1 = 1'b1;
      end
    end
  end

  // Next-state selection and datapath strobes; at most one strobe per state.
  always_comb begin
    state_nxt = state;
    dp_clr_ld = 1'b0;
    dp_add    = 1'b0;
    dp_sub    = 1'b0;
    dp_shift  = 1'b0;
    case (state)
      IDLE: begin
        if (gnt0 || gnt1) state_nxt = LOAD;
      end
      LOAD: begin
        dp_clr_ld = 1'b1;
`ifdef MULT_SCHED_SKIP_EN
        state_nxt = dp_mplr[0] ? ADD : SHIFT;
`else
        state_nxt = ADD;
`endif
      end
      ADD: begin
        dp_add    = dp_m;
        state_nxt = SHIFT;
      end
      SHIFT: begin
        dp_shift = 1'b1;
`ifdef MULT_SCHED_SKIP_EN
        if (last_shift) state_nxt = next_bit ? SUB : SHIFT_LAST;
        else            state_nxt = next_bit ? ADD : SHIFT;
`else
        if (last_shift) state_nxt = SUB;
        else            state_nxt = ADD;
`endif
      end
      SUB: begin
        // Sign-bit correction: the MSB of a two's complement multiplier has
        // negative weight, so it subtracts the multiplicand.
        dp_sub    = dp_m;
        state_nxt = SHIFT_LAST;
      end
      SHIFT_LAST: begin
        dp_shift  = 1'b1;
        state_nxt = CAPTURE;
      end
      CAPTURE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Bit counter, arbitration history and operand latch taken on the grant edge.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt     <= '0;
      owner   <= 1'b0;
      last    <= 1'b1;
      dp_opnd <= '0;
      dp_mplr <= '0;
    end else begin
      if (state == LOAD)       cnt <= '0;
      else if (state == SHIFT) cnt <= cnt_inc;
      if (gnt0 || gnt1) begin
        owner   <= gnt1;
        last    <= gnt1;
        dp_opnd <= gnt1 ? a1 : a0;
        dp_mplr <= gnt1 ? b1 : b0;
      end
    end
  end

  // Product capture and one-cycle done pulse to the owning port.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      done0 <= 1'b0;
      done1 <= 1'b0;
      res0  <= '0;
      res1  <= '0;
    end else begin
      done0 <= 1'b0;
      done1 <= 1'b0;
      if (state == CAPTURE) begin
        if (owner) begin
          res1  <= dp_product;
          done1 <= 1'b1;
        end else begin
          res0  <= dp_product;
          done0 <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mult_sched.sv
// tb_mult_sched: bench for mult_sched with a behavioural shift-add datapath
// (X/A/B registers) answering the strobes, a vector table, randomized
// operations checked against plain signed multiplication, and hand-written
// arbitration and reset sequences.
module tb_mult_sched;

  localparam int W = 8;

  logic             Clk = 1'b0;
  logic             Reset;
  logic             req0, req1;
  logic [W-1:0]     a0, b0, a1, b1;
  logic             gnt0, gnt1, done0, done1;
  logic [2*W-1:0]   res0, res1;
  logic [W-1:0]     dp_opnd, dp_mplr;
  logic             dp_clr_ld, dp_add, dp_sub, dp_shift;
  logic             dp_m;
  logic [2*W-1:0]   dp_product;

  int checks   = 0;
  int failures = 0;

  mult_sched #(.WIDTH(W)) dut (
    .Clk(Clk), .Reset(Reset),
    .req0(req0), .req1(req1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .res0(res0), .res1(res1),
    .dp_opnd(dp_opnd), .dp_mplr(dp_mplr),
    .dp_clr_ld(dp_clr_ld), .dp_add(dp_add), .dp_sub(dp_sub), .dp_shift(dp_shift),
    .dp_m(dp_m), .dp_product(dp_product)
  );

  always #5 Clk = ~Clk;

  // Datapath model: sign flop X, accumulator A, multiplier register B.
  logic         xb;
  logic [W-1:0] ra, rb;
  always @(posedge Clk) begin
    if (dp_clr_ld) begin
      xb <= 1'b0;
      ra <= '0;
      rb <= dp_mplr;
    end else if (dp_add) begin
      {xb, ra} <= {ra[W-1], ra} + {dp_opnd[W-1], dp_opnd};
    end else if (dp_sub) begin
      {xb, ra} <= {ra[W-1], ra} - {dp_opnd[W-1], dp_opnd};
    end else if (dp_shift) begin
      ra <= {xb, ra[W-1:1]};
      rb <= {ra[0], rb[W-1:1]};
    end
  end
  assign dp_m       = rb[0];
  assign dp_product = {ra, rb};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic int exp_latency(input logic [W-1:0] b);
`ifdef MULT_SCHED_SKIP_EN
    return W + 3 + $countones(b[W-2:0]) + int'(b[W-1]);
`else
    return 2 * W + 3;
`endif
  endfunction

  function automatic logic [2*W-1:0] ref_prod(input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [2*W-1:0] p;
    p = $signed(a) * $signed(b);
    return p;
  endfunction

  task automatic do_reset();
    @(negedge Clk);
    Reset = 1'b1;
    req0 = 1'b0; req1 = 1'b0;
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
  endtask

  // One isolated operation on a port; checks grant, latency, product,
  // strobe counts and that the other port is untouched.
  task automatic run_op(input bit port, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2*W-1:0] exp, input string name);
    int lat, n_shift, n_clr, n_add, n_sub, n_multi, n_other_done;
    logic [2*W-1:0] other_before;
    lat = 0; n_shift = 0; n_clr = 0; n_add = 0; n_sub = 0; n_multi = 0; n_other_done = 0;
    @(negedge Clk);
    if (port) begin req1 = 1'b1; a1 = a; b1 = b; end
    else      begin req0 = 1'b1; a0 = a; b0 = b; end
    other_before = port ? res0 : res1;
    #1;
    chk({name, "_gnt"}, {30'd0, gnt1, gnt0}, port ? 32'd2 : 32'd1);
    @(posedge Clk);
    #1;
    req0 = 1'b0; req1 = 1'b0;
    a0 = W'($urandom); b0 = W'($urandom); a1 = W'($urandom); b1 = W'($urandom);
    for (int n = 1; n <= 40; n++) begin
      @(negedge Clk);
      n_shift += int'(dp_shift);
      n_clr   += int'(dp_clr_ld);
      n_add   += int'(dp_add);
      n_sub   += int'(dp_sub);
      if ($countones({dp_clr_ld, dp_add, dp_sub, dp_shift}) > 1) n_multi++;
      if (port ? done0 : done1) n_other_done++;
      if (port ? done1 : done0) begin
        lat = n;
        chk({name, "_strobes_in_done"}, {28'd0, dp_clr_ld, dp_add, dp_sub, dp_shift}, 32'd0);
        break;
      end
    end
    chk({name, "_latency"}, lat, exp_latency(b));
    chk({name, "_res"}, port ? res1 : res0, exp);
    chk({name, "_res_model"}, port ? res1 : res0, ref_prod(a, b));
    chk({name, "_other_res"}, port ? res0 : res1, other_before);
    chk({name, "_other_done"}, n_other_done, 0);
    chk({name, "_nshift"}, n_shift, W);
    chk({name, "_nclr"}, n_clr, 1);
    chk({name, "_nadd"}, n_add, $countones(b[W-2:0]));
    chk({name, "_nsub"}, n_sub, int'(b[W-1]));
    chk({name, "_onehot"}, n_multi, 0);
  endtask

  typedef struct {
    bit             port;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] res;
    string          name;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int gseq[4];
    int gcyc[4];
    int cyc, ng, lat;
    bit seen;

    Reset = 1'b1; req0 = 1'b0; req1 = 1'b0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;

    vecs[0] = '{1'b0, 8'd3,   8'd5,   16'h000F, "p0_3x5"};
    vecs[1] = '{1'b1, 8'hF9,  8'd6,   16'hFFD6, "p1_m7x6"};
    vecs[2] = '{1'b1, 8'h80,  8'h80,  16'h4000, "p1_m128xm128"};
    vecs[3] = '{1'b0, 8'd127, 8'd127, 16'h3F01, "p0_127x127"};
    vecs[4] = '{1'b0, 8'h80,  8'd127, 16'hC080, "p0_m128x127"};
    vecs[5] = '{1'b1, 8'd5,   8'd0,   16'h0000, "p1_b0"};
    vecs[6] = '{1'b0, 8'hFD,  8'hFF,  16'h0003, "p0_m3xm1"};
    vecs[7] = '{1'b0, 8'd37,  8'd0,   16'h0000, "p0_37x0"};
    vecs[8] = '{1'b0, 8'd37,  8'hFF,  16'hFFDB, "p0_37xm1"};

    do_reset();
    #1;
    chk("rst_gnt",     {30'd0, gnt1, gnt0}, 32'd0);
    chk("rst_done",    {30'd0, done1, done0}, 32'd0);
    chk("rst_res",     {res1, res0}, 32'd0);
    chk("rst_strobes", {28'd0, dp_clr_ld, dp_add, dp_sub, dp_shift}, 32'd0);
    chk("rst_dp_regs", {16'd0, dp_opnd, dp_mplr}, 32'd0);

    for (int i = 0; i < 9; i++) run_op(vecs[i].port, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].name);

    for (int i = 0; i < 16; i++) begin
      logic [W-1:0] ra_v, rb_v;
      bit pv;
      ra_v = W'($urandom);
      rb_v = W'($urandom);
      pv   = 1'($urandom_range(0, 1));
      run_op(pv, ra_v, rb_v, ref_prod(ra_v, rb_v), "rand");
    end

    // Both ports held from reset: grants must alternate 0,1,0,1, each one
    // issued in the done cycle of the previous operation.
    do_reset();
    @(negedge Clk);
    a0 = 8'd2; b0 = 8'd3; a1 = 8'd4; b1 = 8'd5;
    req0 = 1'b1; req1 = 1'b1;
    ng = 0;
    cyc = 0;
    while (ng < 4 && cyc < 120) begin
      #1;
      if (gnt0 || gnt1) begin
        gseq[ng] = gnt1 ? 1 : 0;
        gcyc[ng] = cyc;
        if (ng > 0) chk("alt_done_with_gnt", {30'd0, done1, done0}, gseq[ng-1] ? 32'd2 : 32'd1);
        ng++;
      end
      @(negedge Clk);
      cyc++;
    end
    chk("alt_ngrants", ng, 4);
    for (int k = 0; k < 4; k++) chk("alt_order", gseq[k], k % 2);
    for (int k = 1; k < 4; k++) chk("alt_interval", gcyc[k] - gcyc[k-1], 2 * W + 3);
    req0 = 1'b0; req1 = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin
      @(negedge Clk);
      if (done1) seen = 1'b1;
    end
    chk("alt_last_done", seen, 1'b1);
    chk("alt_res0", res0, 16'd6);
    chk("alt_res1", res1, 16'd20);

    // Reset in cycle 8 of an operation: back to idle, no done, results zero.
    do_reset();
    @(negedge Clk);
    req0 = 1'b1; a0 = 8'd3; b0 = 8'd5;
    @(posedge Clk);
    #1;
    req0 = 1'b0;
    repeat (8) @(negedge Clk);
    Reset = 1'b1;
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    @(negedge Clk);
    chk("mid_rst_strobes", {28'd0, dp_clr_ld, dp_add, dp_sub, dp_shift}, 32'd0);
    chk("mid_rst_gnt", {30'd0, gnt1, gnt0}, 32'd0);
    chk("mid_rst_dp_regs", {16'd0, dp_opnd, dp_mplr}, 32'd0);
    lat = 0;
    for (int n = 0; n < 30; n++) begin
      if (done0 || done1) lat++;
      if (dp_clr_ld || dp_add || dp_sub || dp_shift) lat++;
      @(negedge Clk);
    end
    chk("mid_rst_quiet", lat, 0);
    chk("mid_rst_res", {res1, res0}, 32'd0);

    // Operation after the interrupted one still works.
    run_op(1'b0, 8'd3, 8'd5, 16'h000F, "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
